// File: rtl/rps_pkg.sv
// Shared move encodings, round/result codes and controller states for the
// rock-paper-scissors match controller.
package rps_pkg;

    localparam logic [2:0] ROCK     = 3'b001;
    localparam logic [2:0] PAPER    = 3'b010;
    localparam logic [2:0] SCISSORS = 3'b100;

    typedef enum logic [2:0] {
        RES_NONE    = 3'd0,
        RES_A       = 3'd1,
        RES_B       = 3'd2,
        RES_TIE     = 3'd3,
        RES_INVALID = 3'd4
    } result_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_JUDGE   = 3'd2,
        ST_SHOW    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // A move is legal only when exactly one of the three bits is set.
    function automatic logic is_one_hot(input logic [2:0] move);
        return (move == ROCK) || (move == PAPER) || (move == SCISSORS);
    endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: validates both moves and decides the round.
module rps_judge
    import rps_pkg::*;
(
    input  logic [2:0] move_a,
    input  logic [2:0] move_b,
    output result_t    verdict
);

    // Invalid moves dominate, then ties, then the beats-relation for A.
    always_comb begin
        verdict = RES_B;
        if (!is_one_hot(move_a) || !is_one_hot(move_b)) begin
            verdict = RES_INVALID;
        end else if (move_a == move_b) begin
            verdict = RES_TIE;
        end else if (((move_a == ROCK)     && (move_b == SCISSORS)) ||
                     ((move_a == SCISSORS) && (move_b == PAPER))    ||
                     ((move_a == PAPER)    && (move_b == ROCK))) begin
            verdict = RES_A;
        end
    end

endmodule

// File: rtl/rps_match_ctrl.sv
// Best-of-N rock-paper-scissors match sequencer: collects both players'
// committed moves, judges the round, shows the result for a fixed window
// and declares the match winner once a side reaches WIN_TARGET.
module rps_match_ctrl
    import rps_pkg::*;
#(
    parameter int WIN_TARGET    = 3,
    parameter int SCORE_W       = 4,
    parameter int RESULT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [2:0]         inA,
    input  logic [2:0]         inB,
    input  logic               lock_a,
    input  logic               lock_b,
    output logic               waiting_a,
    output logic               waiting_b,
    output result_t            result,
    output logic               result_valid,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               match_done,
    output result_t            match_winner
);

    localparam int CNT_W = $clog2(RESULT_CYCLES + 1);
    localparam logic [SCORE_W-1:0] TARGET   = SCORE_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0]   SHOW_TOP = CNT_W'(RESULT_CYCLES - 1);

    state_t             state;
    logic [2:0]         move_a;
    logic [2:0]         move_b;
    logic               a_got;
    logic               b_got;
    logic [CNT_W-1:0]   show_cnt;
    result_t            verdict;

    rps_judge u_judge (
        .move_a  (move_a),
        .move_b  (move_b),
        .verdict (verdict)
    );

    // Match FSM with move capture, score counters and the display-window timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            move_a   <= 3'b000;
            move_b   <= 3'b000;
            a_got    <= 1'b0;
            b_got    <= 1'b0;
            show_cnt <= '0;
            result   <= RES_NONE;
            score_a  <= '0;
            score_b  <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
            a_got    <= 1'b0;
            b_got    <= 1'b0;
            show_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        score_a <= '0;
                        score_b <= '0;
                        state   <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (lock_a && !a_got) begin
                        move_a <= inA;
                        a_got  <= 1'b1;
                    end
                    if (lock_b && !b_got) begin
                        move_b <= inB;
                        b_got  <= 1'b1;
                    end
                    if ((a_got || lock_a) && (b_got || lock_b)) begin
                        state <= ST_JUDGE;
                    end
                end
                ST_JUDGE: begin
                    result <= verdict;
                    if (verdict == RES_A) begin
                        score_a <= score_a + SCORE_W'(1);
                    end
                    if (verdict == RES_B) begin
                        score_b <= score_b + SCORE_W'(1);
                    end
                    show_cnt <= SHOW_TOP;
                    state    <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (show_cnt == '0) begin
                        a_got <= 1'b0;
                        b_got <= 1'b0;
                        if ((score_a == TARGET) || (score_b == TARGET)) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end else begin
                        show_cnt <= show_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        score_a <= '0;
                        score_b <= '0;
                        state   <= ST_COLLECT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign waiting_a    = (state == ST_COLLECT) && !a_got;
    assign waiting_b    = (state == ST_COLLECT) && !b_got;
    assign result_valid = (state == ST_SHOW);
    assign match_done   = (state == ST_DONE);

    // The winner is reported only while the match is over.
    always_comb begin
        match_winner = RES_NONE;
        if (state == ST_DONE) begin
            match_winner = (score_a == TARGET) ? RES_A : RES_B;
        end
    end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Randomised scoreboard bench for rps_match_ctrl: a high-level model of the
// game rules predicts each round; a monitor compares on every result window.
module tb_rps_match_ctrl;
    import rps_pkg::*;

    localparam int WIN_TARGET    = 3;
    localparam int SCORE_W       = 4;
    localparam int RESULT_CYCLES = 4;

    typedef struct {
        logic [2:0] res;
        int         sa;
        int         sb;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [2:0]         inA = 3'b000;
    logic [2:0]         inB = 3'b000;
    logic               lock_a = 1'b0;
    logic               lock_b = 1'b0;
    logic               waiting_a;
    logic               waiting_b;
    logic [2:0]         result;
    logic               result_valid;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic               match_done;
    logic [2:0]         match_winner;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    int   model_sa = 0;
    int   model_sb = 0;
    logic [2:0] model_last = RES_NONE;

    rps_match_ctrl #(
        .WIN_TARGET    (WIN_TARGET),
        .SCORE_W       (SCORE_W),
        .RESULT_CYCLES (RESULT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .inA          (inA),
        .inB          (inB),
        .lock_a       (lock_a),
        .lock_b       (lock_b),
        .waiting_a    (waiting_a),
        .waiting_b    (waiting_b),
        .result       (result),
        .result_valid (result_valid),
        .score_a      (score_a),
        .score_b      (score_b),
        .match_done   (match_done),
        .match_winner (match_winner)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Game rules as arithmetic: index moves 0..2 (rock, paper, scissors);
    // A wins when its index is one ahead of B's modulo 3.
    function automatic logic [2:0] model_judge(input logic [2:0] a, input logic [2:0] b);
        int ia;
        int ib;
        if ($countones(a) != 1 || $countones(b) != 1) return RES_INVALID;
        ia = 0;
        ib = 0;
        for (int i = 0; i < 3; i++) begin
            if (a[i]) ia = i;
            if (b[i]) ib = i;
        end
        case ((ia - ib + 3) % 3)
            0:       return RES_TIE;
            1:       return RES_A;
            default: return RES_B;
        endcase
    endfunction

    task automatic push_expected(input logic [2:0] a, input logic [2:0] b);
        exp_t e;
        e.res = model_judge(a, b);
        if (e.res == RES_A) model_sa++;
        if (e.res == RES_B) model_sb++;
        e.sa = model_sa;
        e.sb = model_sb;
        model_last = e.res;
        sb_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic la, input logic lb, input logic [2:0] ma, input logic [2:0] mb);
        @(posedge clk);
        #1;
        inA    = ma;
        inB    = mb;
        lock_a = la;
        lock_b = lb;
        @(posedge clk);
        #1;
        lock_a = 1'b0;
        lock_b = 1'b0;
    endtask

    task automatic start_match();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        model_sa = 0;
        model_sb = 0;
        check_output("start_score_a", int'(score_a), 0);
        check_output("start_score_b", int'(score_b), 0);
        check_output("start_waiting_a", int'(waiting_a), 1);
        check_output("start_done", int'(match_done), 0);
    endtask

    task automatic wait_round_end();
        int   n = 0;
        logic seen = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (result_valid) seen = 1'b1;
            else if (seen) break;
        end
        if (n >= 40) check_output("round_timeout", n, 0);
    endtask

    // mode 0: A then B; mode 1: simultaneous; mode 2: A twice (first kept), then B.
    task automatic play_round(input logic [2:0] ma, input logic [2:0] mb, input int mode);
        if (mode == 1) begin
            push_expected(ma, mb);
            apply_stimulus(1'b1, 1'b1, ma, mb);
        end else begin
            apply_stimulus(1'b1, 1'b0, ma, mb);
            check_output("after_lock_a_waiting_a", int'(waiting_a), 0);
            check_output("after_lock_a_waiting_b", int'(waiting_b), 1);
            if (mode == 2) apply_stimulus(1'b1, 1'b0, ~ma, mb);
            push_expected(ma, mb);
            apply_stimulus(1'b0, 1'b1, ~ma, mb);
        end
        wait_round_end();
        if (model_sa == WIN_TARGET || model_sb == WIN_TARGET) begin
            check_output("done_flag", int'(match_done), 1);
            check_output("done_winner", int'(match_winner),
                         (model_sa == WIN_TARGET) ? int'(RES_A) : int'(RES_B));
        end else begin
            check_output("next_waiting_a", int'(waiting_a), 1);
            check_output("next_waiting_b", int'(waiting_b), 1);
            check_output("next_done", int'(match_done), 0);
        end
    endtask

    function automatic logic [2:0] random_move();
        int r = $urandom_range(0, 7);
        if (r < 6) return 3'(1 << (r % 3));
        return 3'($urandom_range(0, 7));
    endfunction

    // Monitor: compare each result window against the scoreboard and time its length.
    initial begin
        logic prev_valid = 1'b0;
        int   win_len = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
                win_len    = 0;
            end else begin
                if (result_valid) begin
                    if (!prev_valid) begin
                        if (sb_q.size() == 0) begin
                            check_output("unexpected_result", 1, 0);
                        end else begin
                            e = sb_q.pop_front();
                            check_output("round_result", int'(result), int'(e.res));
                            check_output("round_score_a", int'(score_a), e.sa);
                            check_output("round_score_b", int'(score_b), e.sb);
                        end
                    end
                    win_len++;
                end else if (prev_valid) begin
                    check_output("show_length", win_len, RESULT_CYCLES);
                    win_len = 0;
                end
                prev_valid = result_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        #12;
        check_output("reset_result", int'(result), int'(RES_NONE));
        check_output("reset_valid", int'(result_valid), 0);
        check_output("reset_score_a", int'(score_a), 0);
        check_output("reset_done", int'(match_done), 0);
        check_output("reset_waiting_a", int'(waiting_a), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed rounds from the plan, then A closes out the match.
        start_match();
        play_round(ROCK, SCISSORS, 0);
        play_round(PAPER, PAPER, 1);
        play_round(3'b011, ROCK, 1);
        play_round(3'b000, ROCK, 0);
        play_round(ROCK, PAPER, 2);
        play_round(ROCK, SCISSORS, 1);
        play_round(SCISSORS, PAPER, 0);

        // Locks in DONE must not start a round or touch scores.
        apply_stimulus(1'b1, 1'b1, PAPER, ROCK);
        repeat (3) @(posedge clk);
        #1;
        check_output("done_lock_ignored", int'(match_done), 1);
        check_output("done_score_a", int'(score_a), 3);
        check_output("done_result_held", int'(result), int'(RES_A));
        start_match();

        // Randomised rounds across several matches.
        for (int r = 0; r < 30; r++) begin
            play_round(random_move(), random_move(), int'($urandom_range(0, 2)));
            if (model_sa == WIN_TARGET || model_sb == WIN_TARGET) start_match();
        end

        // Abort mid-collect: idle next cycle, scores and result held.
        apply_stimulus(1'b1, 1'b0, ROCK, ROCK);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check_output("abort_waiting_a", int'(waiting_a), 0);
        check_output("abort_valid", int'(result_valid), 0);
        check_output("abort_score_a", int'(score_a), model_sa);
        check_output("abort_score_b", int'(score_b), model_sb);
        check_output("abort_result", int'(result), int'(model_last));
        check_output("abort_done", int'(match_done), 0);
        start_match();

        // Reset mid-show clears every output immediately.
        push_expected(PAPER, ROCK);
        apply_stimulus(1'b1, 1'b1, PAPER, ROCK);
        n = 0;
        while (!result_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("show_reached", int'(result_valid), 1);
        #2 reset = 1'b1;
        #1;
        check_output("midshow_reset_valid", int'(result_valid), 0);
        check_output("midshow_reset_result", int'(result), int'(RES_NONE));
        check_output("midshow_reset_score_a", int'(score_a), 0);
        check_output("midshow_reset_winner", int'(match_winner), int'(RES_NONE));
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        start_match();
        play_round(SCISSORS, ROCK, 1);

        repeat (5) @(posedge clk);
        check_output("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rps_match_ctrl.md
Name: rps_match_ctrl

Overview:
- Sequences a best-of-N rock-paper-scissors match between player A and player B.
- Captures each player's committed 3-bit one-hot move and checks that each move is valid (exactly one bit set).
- Judges each round, keeps the two scores, holds each round result for a fixed display window, and declares the match winner.
- Sits between the player input logic (switch or button sync) and the display/LED driver.

Parameters:
- WIN_TARGET, 3: number of round wins that ends the match; must be at least 1.
- SCORE_W, 4: width of each score counter; must satisfy 2**SCORE_W > WIN_TARGET.
- RESULT_CYCLES, 4: number of cycles result_valid is held per round; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new match (accepted in IDLE or DONE only).
- abort  in  1  synchronous; returns to IDLE from any state, scores held.
- inA  in  3  player A move: 001 rock, 010 paper, 100 scissors.
- inB  in  3  player B move, same encoding as inA.
- lock_a  in  1  player A commit strobe.
- lock_b  in  1  player B commit strobe.
- waiting_a  out  1  high in COLLECT while A has not locked.
- waiting_b  out  1  high in COLLECT while B has not locked.
- result  out  3  result_t of the last judged round.
- result_valid  out  1  high during the SHOW window.
- score_a  out  SCORE_W  rounds won by A.
- score_b  out  SCORE_W  rounds won by B.
- match_done  out  1  high in DONE.
- match_winner  out  3  RES_A or RES_B in DONE, RES_NONE otherwise.

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0 / RES_NONE; captured moves and captured flags cleared.
- States: IDLE, COLLECT, JUDGE, SHOW, DONE.
- IDLE: on start -> COLLECT; score_a and score_b cleared to 0.
- COLLECT: lock_a and lock_b are sampled only in this state.
  - First lock_a captures inA and sets a_got; later lock_a pulses are ignored. Same rule for B.
  - Both locks in the same cycle capture both moves.
  - When both flags are set after the current edge (including captures made on that edge) -> JUDGE.
- JUDGE: exactly one cycle.
  - Either captured move not one-hot (000, 011, 111, ...) -> result = RES_INVALID; no score change.
  - Moves equal -> RES_TIE; no score change.
  - Rock beats scissors, scissors beats paper, paper beats rock -> RES_A or RES_B; the winner's score increments by 1.
  - result and scores are registered on the JUDGE->SHOW edge -> SHOW.
- SHOW: result_valid = 1 for exactly RESULT_CYCLES cycles, using an internal down-counter.
  - After the last cycle: if score_a or score_b equals WIN_TARGET -> DONE; otherwise -> COLLECT.
  - On exit, a_got and b_got are cleared.
- DONE: match_done = 1; match_winner = side that reached WIN_TARGET; result and scores held.
  - start -> COLLECT with scores cleared; match_done falls on the same edge.
- Latency: second lock at edge N -> JUDGE in cycle N+1 -> result_valid high from edge N+2 through N+1+RESULT_CYCLES.
- start while in COLLECT, JUDGE or SHOW: ignored.
- abort has priority over start and locks. Next state is IDLE; result_valid, match_done and captured flags clear; scores and result hold.
- result holds its last value outside SHOW; result_valid is the only qualifier.
- Scores never exceed WIN_TARGET; no wrap-around is possible.

Decomposition:
- Package rps_pkg:
  - move constants ROCK = 3'b001, PAPER = 3'b010, SCISSORS = 3'b100.
  - typedef enum logic[2:0] result_t: RES_NONE = 0, RES_A = 1, RES_B = 2, RES_TIE = 3, RES_INVALID = 4.
  - typedef enum state_t for the five FSM states.
- Sub-module rps_judge (combinational): takes two 3-bit moves and returns result_t, including the one-hot validity check. The controller holds the FSM, capture registers, score counters and SHOW counter.

Test Plan:
1. Reset, start; lock_a with inA = 001; two cycles later lock_b with inB = 100 -> two cycles after lock_b, result_valid high for 4 cycles, result = RES_A, score_a = 1, score_b = 0.
2. lock_a and lock_b in the same cycle, inA = inB = 010 -> result = RES_TIE; scores unchanged; FSM returns to COLLECT with waiting_a = waiting_b = 1.
3. inA = 011 or 000, inB = 001 -> result = RES_INVALID; scores unchanged; a new round collects normally.
4. lock_a with inA = 001, then lock_a with inA = 010, then lock_b with inB = 010 -> result = RES_B (first capture kept, paper beats rock).
5. A wins 3 rounds -> match_done = 1, match_winner = RES_A, score_a = 3. Locks in DONE are ignored; start -> scores 0, waiting_a = 1.
6. Assert reset mid-SHOW, and separately abort mid-COLLECT -> reset clears all outputs immediately; abort gives IDLE next cycle with scores held and result_valid = 0.
